// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: address match (7/10-bit), data byte capture, open-drain ACK drive.
// Fully synchronous to clk; scl/sda are oversampled through a synchronizer chain.
module i2c_slave_rx #(
  parameter logic [9:0] OWN_ADDR    = 10'h2A5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       addr_len10,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rdy,
  output logic       addr_hit,
  output logic       rd_req,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR1, ADDR2, DATA, ACK, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_n, ack_next, ack_next_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, rx_data_n, byte_in;
  logic       sda_oe_n, rx_valid_n, rd_req_n, addr_hit_n, busy_n;
  logic       mode10, mode10_n;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {shift[6:0], sda_s};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n    = state;
    ack_next_n = ack_next;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rd_req_n   = 1'b0;
    addr_hit_n = addr_hit;
    busy_n     = busy;
    mode10_n   = mode10;

    if (start_det) begin
      state_n    = ADDR1;
      bit_cnt_n  = 4'd0;
      addr_hit_n = 1'b0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b1;
      mode10_n   = addr_len10;
    end else if (stop_det) begin
      state_n    = IDLE;
      bit_cnt_n  = 4'd0;
      addr_hit_n = 1'b0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
    end else begin
      case (state)
        ADDR1, ADDR2, DATA: begin
          if (scl_rise) begin
            shift_n = byte_in;
            if (bit_cnt == 4'd7) begin
              // Eighth bit: decide ACK now; anything not accepted falls to IGNORE.
              bit_cnt_n = 4'd8;
              state_n   = IGNORE;
              case (state)
                ADDR1: begin
                  if (mode10) begin
                    if (byte_in == {5'b11110, OWN_ADDR[9:8], 1'b0}) begin
                      state_n    = ACK;
                      ack_next_n = ADDR2;
                    end
                  end else if (byte_in[7:1] == OWN_ADDR[6:0]) begin
                    if (byte_in[0]) begin
                      rd_req_n = 1'b1;
                    end else begin
                      state_n    = ACK;
                      ack_next_n = DATA;
                      addr_hit_n = 1'b1;
                    end
                  end
                end
                ADDR2: begin
                  if (byte_in == OWN_ADDR[7:0]) begin
                    state_n    = ACK;
                    ack_next_n = DATA;
                    addr_hit_n = 1'b1;
                  end
                end
                default: begin
                  if (rx_rdy) begin
                    state_n    = ACK;
                    ack_next_n = DATA;
                    rx_data_n  = byte_in;
                    rx_valid_n = 1'b1;
                  end
                end
              endcase
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        ACK: begin
          // First falling edge opens the ACK slot, the next one closes it.
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = ack_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: synchronizers reset to the idle-bus level (1) so reset release never looks like START/STOP.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      ack_next <= IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rd_req   <= 1'b0;
      addr_hit <= 1'b0;
      busy     <= 1'b0;
      mode10   <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      state    <= state_n;
      ack_next <= ack_next_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rd_req   <= rd_req_n;
      addr_hit <= addr_hit_n;
      busy     <= busy_n;
      mode10   <= mode10_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a bus-master model drives frames on a wired-AND SDA;
// received bytes are checked against a scoreboard queue filled as bytes are sent.
module tb_i2c_slave_rx;

  localparam int Q = 20;  // clk cycles per quarter SCL bit

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       addr_len10 = 1'b0;
  logic       rx_rdy = 1'b1;
  logic       sda_oe, rx_valid, addr_hit, rd_req, busy;
  logic [7:0] rx_data;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int rdreq_cnt = 0;
  logic oe_seen = 1'b0;
  logic [7:0] exp_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .addr_len10(addr_len10), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_rdy(rx_rdy), .addr_hit(addr_hit), .rd_req(rd_req), .busy(busy)
  );

  // Scoreboard and pulse monitors, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (rd_req) rdreq_cnt++;
      if (rx_valid) begin
        valid_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: unexpected rx_valid, rx_data=%h, nothing expected", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            fails++;
            $display("FAIL scoreboard: rx_data=%h expected %h", rx_data, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic sampled);
    sda_m = b;   tick(Q);
    scl = 1'b1;  tick(Q);
    sampled = sda_bus; tick(Q);
    scl = 1'b0;  tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    tests++;
    if ({sda_oe, rx_valid, addr_hit, rd_req, busy} !== 5'b0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset: oe/valid/hit/rdreq/busy=%b rx_data=%h expected 00000/00",
               {sda_oe, rx_valid, addr_hit, rd_req, busy}, rx_data);
    end
    rst = 1'b1;
    tick(5);
    tests++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: busy=%b sda_oe=%b expected 0/0", busy, sda_oe);
    end
  endtask

  task automatic test_write7;
    logic ack;
    valid_cnt = 0;
    bus_start;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL w7_busy: busy=%b expected 1", busy); end
    send_byte(8'h4A, ack);
    tests++;
    if (ack !== 1'b1) begin fails++; $display("FAIL w7_addr_ack: ack=%b expected 1", ack); end
    tests++;
    if (addr_hit !== 1'b1) begin fails++; $display("FAIL w7_hit: addr_hit=%b expected 1", addr_hit); end
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, ack);
    tests++;
    if (ack !== 1'b1) begin fails++; $display("FAIL w7_data_ack: ack=%b expected 1", ack); end
    tests++;
    if (addr_hit !== 1'b1) begin fails++; $display("FAIL w7_hit_hold: addr_hit=%b expected 1", addr_hit); end
    bus_stop;
    tests++;
    if (addr_hit !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL w7_stop: addr_hit=%b busy=%b expected 0/0", addr_hit, busy);
    end
    tests++;
    if (valid_cnt != 1 || exp_q.size() != 0) begin
      fails++; $display("FAIL w7_count: rx_valid pulses=%0d pending=%0d expected 1/0", valid_cnt, exp_q.size());
    end
  endtask

  task automatic test_wrong_addr;
    logic ack;
    valid_cnt = 0;
    oe_seen = 1'b0;
    bus_start;
    send_byte(8'h4C, ack);
    tests++;
    if (ack !== 1'b0) begin fails++; $display("FAIL wa_nack: ack=%b expected 0", ack); end
    send_byte(8'h55, ack);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL wa_busy: busy=%b expected 1", busy); end
    bus_stop;
    tests++;
    if (oe_seen !== 1'b0 || valid_cnt != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL wa_quiet: oe_seen=%b rx_valid pulses=%0d busy=%b expected 0/0/0",
                        oe_seen, valid_cnt, busy);
    end
  endtask

  task automatic test_10bit;
    logic a1, a2, a3;
    valid_cnt = 0;
    addr_len10 = 1'b1;
    bus_start;
    addr_len10 = 1'b0;  // mode must already be latched at START
    send_byte(8'hF4, a1);
    send_byte(8'hA5, a2);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, a3);
    bus_stop;
    tests++;
    if ({a1, a2, a3} !== 3'b111 || rx_data !== 8'h5A) begin
      fails++; $display("FAIL a10_match: acks=%b rx_data=%h expected 111/5a", {a1, a2, a3}, rx_data);
    end
    addr_len10 = 1'b1;
    oe_seen = 1'b0;
    bus_start;
    send_byte(8'hF4, a1);
    send_byte(8'hA4, a2);
    oe_seen = 1'b0;
    send_byte(8'h33, a3);
    bus_stop;
    addr_len10 = 1'b0;
    tests++;
    if ({a1, a2, a3} !== 3'b100 || oe_seen !== 1'b0 || valid_cnt != 1) begin
      fails++; $display("FAIL a10_miss: acks=%b oe_after=%b rx_valid pulses=%0d expected 100/0/1",
                        {a1, a2, a3}, oe_seen, valid_cnt);
    end
  endtask

  task automatic test_not_ready;
    logic a1, a2, a3;
    valid_cnt = 0;
    bus_start;
    send_byte(8'h4A, a1);
    exp_q.push_back(8'hE7);
    send_byte(8'hE7, a2);
    rx_rdy = 1'b0;
    send_byte(8'h11, a3);
    rx_rdy = 1'b1;
    bus_stop;
    tests++;
    if ({a1, a2, a3} !== 3'b110 || valid_cnt != 1 || rx_data !== 8'hE7) begin
      fails++; $display("FAIL not_ready: acks=%b rx_valid pulses=%0d rx_data=%h expected 110/1/e7",
                        {a1, a2, a3}, valid_cnt, rx_data);
    end
  endtask

  task automatic test_repeated_start;
    logic a1, a2, a3;
    valid_cnt = 0;
    rdreq_cnt = 0;
    bus_start;
    send_byte(8'h4B, a1);
    tests++;
    if (a1 !== 1'b0 || rdreq_cnt != 1 || addr_hit !== 1'b0) begin
      fails++; $display("FAIL rd_req: ack=%b rd_req pulses=%0d addr_hit=%b expected 0/1/0",
                        a1, rdreq_cnt, addr_hit);
    end
    bus_start;  // repeated START
    send_byte(8'h4A, a2);
    exp_q.push_back(8'h77);
    send_byte(8'h77, a3);
    bus_stop;
    tests++;
    if ({a2, a3} !== 2'b11 || rx_data !== 8'h77 || valid_cnt != 1 || rdreq_cnt != 1) begin
      fails++; $display("FAIL rep_start: acks=%b rx_data=%h valid=%0d rdreq=%0d expected 11/77/1/1",
                        {a2, a3}, rx_data, valid_cnt, rdreq_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write7();
    test_wrong_addr();
    test_10bit();
    test_not_ready();
    test_repeated_start();
    test_reset_mid_ack();
    tick(10);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL leftover: %0d expected bytes never delivered, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic test_reset_mid_ack;
    logic a1, a2, s;
    logic [7:0] b;
    b = 8'hAB;
    bus_start;
    send_byte(8'h4A, a1);
    exp_q.push_back(8'hAB);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    tests++;
    if (a1 !== 1'b1 || sda_oe !== 1'b1) begin
      fails++; $display("FAIL ack_slot: addr ack=%b sda_oe=%b expected 1/1", a1, sda_oe);
    end
    valid_cnt = 0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (sda_oe !== 1'b0 || addr_hit !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL async_reset: sda_oe=%b addr_hit=%b busy=%b expected 0/0/0",
                        sda_oe, addr_hit, busy);
    end
    tick(2);
    rst = 1'b1;
    oe_seen = 1'b0;
    bus_bit(1'b1, s);
    send_byte(8'h4A, a2);
    bus_stop;
    tests++;
    if (a2 !== 1'b0 || oe_seen !== 1'b0 || valid_cnt != 0) begin
      fails++; $display("FAIL post_reset_ignore: ack=%b oe_seen=%b rx_valid pulses=%0d expected 0/0/0",
                        a2, oe_seen, valid_cnt);
    end
  endtask

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter OWN_ADDR, default 10'h2A5, slave address compared against the received address (low 7 bits used in 7-bit mode).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for scl/sda.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port scl  input  1  I2C clock from the bus master.
REQ-006 SHALL have port sda_in  input  1  sampled bus SDA level.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain ACK); 0 = release.
REQ-008 SHALL have port addr_len10  input  1  1 = 10-bit addressing, 0 = 7-bit; sampled at START only.
REQ-009 SHALL have port rx_data  output  8  last received data byte.
REQ-010 SHALL have port rx_valid  output  1  one-clk pulse, rx_data updated.
REQ-011 SHALL have port rx_rdy  input  1  sink can accept a byte; 0 at ACK time -> NACK.
REQ-012 SHALL have port addr_hit  output  1  high from own-address ACK until STOP/START.
REQ-013 SHALL have port rd_req  output  1  one-clk pulse: own address matched with R/W=1 (read not served).
REQ-014 SHALL have port busy  output  1  high between detected START and STOP.

Function
REQ-015 SHALL pass scl and sda_in through SYNC_STAGES flops; all edge detection uses synchronized values plus one history flop.
REQ-016 SHALL detect START as synchronized SDA 1->0 while SCL high, STOP as SDA 1->0... no: STOP as SDA 0->1 while SCL high; detection in the clk after the edge appears at synchronizer output.
REQ-017 SHALL sample SDA on each detected SCL rising edge; shift MSB first into an 8-bit shift register.
REQ-018 SHALL use a 4-bit bit counter, 0..8: bits 0-7 data/address, bit 8 = ACK slot.
REQ-019 SHALL implement states IDLE, ADDR1, ADDR2, DATA, ACK, IGNORE.
REQ-020 IDLE -> ADDR1 on START; any state -> ADDR1 on START (repeated START), bit counter cleared, addr_hit cleared.
REQ-021 any state -> IDLE on STOP; sda_oe deasserted in the same clk.
REQ-022 ADDR1, 7-bit mode: after 8 bits, match = byte[7:1]==OWN_ADDR[6:0]; R/W = byte[0].
REQ-023 ADDR1, 10-bit mode: first byte must be {5'b11110, OWN_ADDR[9:8], 0}; on match -> ADDR2, else IGNORE.
REQ-024 ADDR2: second byte must equal OWN_ADDR[7:0]; match -> DATA via ACK, else IGNORE.
REQ-025 Match with R/W=0 SHALL ACK and enter DATA; match with R/W=1 SHALL pulse rd_req, NACK, enter IGNORE.
REQ-026 DATA: after 8th bit, rx_data <= shift reg, rx_valid pulses one clk on the 8th SCL rising edge, then ACK slot.
REQ-027 ACK drive: sda_oe asserts on the SCL falling edge after bit 7 (if ACKing) and releases on the next SCL falling edge.
REQ-028 Data byte ACKed only if rx_rdy=1 at the 8th SCL rising edge; else NACK, rx_valid not pulsed, -> IGNORE.
REQ-029 IGNORE: sda_oe stays 0, no outputs change, waits for START or STOP.
REQ-030 Non-matching address SHALL never assert sda_oe.
REQ-031 busy SHALL rise the clk after START detection and fall the clk after STOP detection.

Reset
REQ-032 On rst=0, immediately: state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, addr_hit=0, rd_req=0, busy=0, counters and synchronizers cleared to idle-bus (scl=1, sda=1) values.
REQ-033 Reset mid-frame SHALL release SDA at once; after release the block waits for a fresh START.

Verification
REQ-034 7-bit: START, byte 8'h4A (addr 0x25, W)... with OWN_ADDR=10'h025, then data 8'hC3, STOP -> ACK both, rx_valid once with rx_data=8'hC3, addr_hit high until STOP.
REQ-035 7-bit wrong address 8'h4C -> sda_oe never asserted, no rx_valid, busy still 1 until STOP.
REQ-036 10-bit OWN_ADDR=10'h2A5: bytes 8'hF4, 8'hA5, 8'h5A -> three ACKs, rx_data=8'h5A; with second byte 8'hA4 -> NACK, IGNORE.
REQ-037 rx_rdy=0 during second data byte 8'h11 -> first byte ACKed and delivered, second NACKed, no second rx_valid.
REQ-038 Repeated START after address 8'h4B (R) -> rd_req pulses once, NACK; following 8'h4A + data 8'h77 ACKed, rx_data=8'h77.
REQ-039 rst=0 while sda_oe=1 in an ACK slot -> sda_oe=0 without a clk edge; after rst=1 data bits ignored until next START.
